// File: rtl/wall_drawer.sv
// Moving-wall sprite engine: erases the wall, steps it one column left, then redraws it with a gap.
// Optional macro WALL_RANDOM_GAP_EN selects LFSR-driven gap heights instead of the fixed sequence.
module wall_drawer #(
    parameter int          SCREEN_W    = 160,
    parameter int          SCREEN_H    = 120,
    parameter int          WALL_W      = 4,
    parameter int          GAP_H       = 40,
    parameter logic [2:0]  WALL_COLOUR = 3'b010
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       touched,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       done,
    output logic [7:0] wall_x,
    output logic [6:0] gap_y
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ERASE = 3'd1;
    localparam logic [2:0] S_MOVE  = 3'd2;
    localparam logic [2:0] S_DRAW  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam int         CW      = (WALL_W > 1) ? $clog2(WALL_W) : 1;

    logic [2:0]    state_q, state_d;
    logic [6:0]    row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [7:0]    wall_x_q, wall_x_d;
    logic [6:0]    gap_y_q, gap_y_d;
    logic [6:0]    next_gap_s;
    logic          last_col_s;
    logic          last_pixel_s;
    logic          scanning_s;
    logic          in_gap_s;

    assign last_col_s   = (col_q == CW'(WALL_W - 1));
    assign last_pixel_s = last_col_s && (row_q == 7'(SCREEN_H - 1));

`ifdef WALL_RANDOM_GAP_EN
    logic [6:0] lfsr_q, lfsr_d;

    // Free-running x^7+x^6+1 LFSR; gap sits 8 rows below the top plus its low six bits.
    always_comb begin
        lfsr_d     = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
        next_gap_s = 7'd8 + {1'b0, lfsr_q[5:0]};
    end

    // LFSR register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lfsr_q <= 7'h5A;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    logic [1:0] gap_idx_q, gap_idx_d;

    // Fixed gap sequence 16, 64, 28, 40; index advances only when a new gap is consumed.
    always_comb begin
        case (gap_idx_q)
            2'd0:    next_gap_s = 7'd16;
            2'd1:    next_gap_s = 7'd64;
            2'd2:    next_gap_s = 7'd28;
            default: next_gap_s = 7'd40;
        endcase
        if (state_q == S_MOVE && wall_x_q == 8'd0) begin
            gap_idx_d = gap_idx_q + 2'd1;
        end else begin
            gap_idx_d = gap_idx_q;
        end
    end

    // Gap sequence index register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            gap_idx_q <= 2'd0;
        end else begin
            gap_idx_q <= gap_idx_d;
        end
    end
`endif

    // Sequencer: scan counters walk row-major over the wall footprint in ERASE and DRAW.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        wall_x_d = wall_x_q;
        gap_y_d  = gap_y_q;
        case (state_q)
            S_IDLE: begin
                row_d = 7'd0;
                col_d = '0;
                if (start) begin
                    state_d = touched ? S_DONE : S_ERASE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ERASE, S_DRAW: begin
                if (last_pixel_s) begin
                    row_d   = 7'd0;
                    col_d   = '0;
                    state_d = (state_q == S_ERASE) ? S_MOVE : S_DONE;
                end else if (last_col_s) begin
                    row_d = row_q + 7'd1;
                    col_d = '0;
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
            S_MOVE: begin
                state_d = S_DRAW;
                if (wall_x_q == 8'd0) begin
                    wall_x_d = 8'(SCREEN_W - WALL_W);
                    gap_y_d  = next_gap_s;
                end else begin
                    wall_x_d = wall_x_q - 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            row_q    <= 7'd0;
            col_q    <= '0;
            wall_x_q <= 8'(SCREEN_W - WALL_W);
            gap_y_q  <= 7'd40;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            wall_x_q <= wall_x_d;
            gap_y_q  <= gap_y_d;
        end
    end

    // Pixel outputs decode straight from state/counters so the VGA write lands in the scan cycle;
    // gating with resetn keeps them quiet for the whole reset window.
    always_comb begin
        scanning_s = (state_q == S_ERASE) || (state_q == S_DRAW);
        in_gap_s   = ({1'b0, row_q} >= {1'b0, gap_y_q}) &&
                     ({1'b0, row_q} <= ({1'b0, gap_y_q} + 8'(GAP_H - 1)));
        if (resetn && scanning_s) begin
            plot = 1'b1;
            x    = wall_x_q + 8'(col_q);
            y    = row_q;
            if (state_q == S_DRAW && !in_gap_s) begin
                colour = WALL_COLOUR;
            end else begin
                colour = 3'b000;
            end
        end else begin
            plot   = 1'b0;
            x      = 8'd0;
            y      = 7'd0;
            colour = 3'b000;
        end
        done = resetn && (state_q == S_DONE);
    end

    assign wall_x = wall_x_q;
    assign gap_y  = gap_y_q;
endmodule
